rom_load_ctrl: RTL and testbench
================================

ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, max clk_sys cycles in WRITE awaiting rom_ack.
REQ-002 SHALL have parameter RESET_HOLD, default 1024, clk_sys cycles board_reset stays high after ROM download ends.
REQ-003 SHALL have port clk_sys  in  1  system clock; sole clock of the block.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports ioctl_download in 1, ioctl_wr in 1, ioctl_index in 8, ioctl_addr in 25, ioctl_dout in 8: download bus from hps_io.
REQ-006 SHALL have port ioctl_wait  out  1  stall to hps_io while a ROM byte is in flight.
REQ-007 SHALL have ports rom_sel out 3 (region = ioctl_addr[18:16]), rom_addr out 16 (ioctl_addr[15:0]), rom_data out 8, rom_we out 1: ROM write request.
REQ-008 SHALL have port rom_ack  in  1  target has accepted the write.
REQ-009 SHALL have ports mod out 8 (game-variant byte), sw out 64 (DIP bytes 0..7, byte n at [8n+7:8n]).
REQ-010 SHALL have ports board_reset out 1, rom_ready out 1, err_timeout out 1, err_overrun out 1.

Function
REQ-011 SHALL implement FSM IDLE, WRITE, HOLD, READY.
REQ-012 IDLE: ioctl_wr with index 0 and ioctl_addr < 0x80000 SHALL latch sel/addr/data and enter WRITE; rom_we and ioctl_wait SHALL be high from the next cycle (latency 1).
REQ-013 Index-0 writes with ioctl_addr >= 0x80000 SHALL be dropped: no rom_we, no stall.
REQ-014 WRITE: rom_ack high SHALL return to IDLE, with rom_we and ioctl_wait low the following cycle; rom_data/rom_addr/rom_sel SHALL be stable throughout WRITE.
REQ-015 WRITE: ACK_TIMEOUT cycles without rom_ack SHALL set sticky err_timeout and return to IDLE, releasing rom_we and ioctl_wait.
REQ-016 ioctl_wr while in WRITE SHALL be ignored and SHALL set sticky err_overrun.
REQ-017 rom_ack outside WRITE SHALL be ignored.
REQ-018 ioctl_wr with index 1 and ioctl_addr==0 SHALL load mod <= ioctl_dout in the next cycle, in any state; no stall.
REQ-019 ioctl_wr with index 254 and ioctl_addr[24:3]==0 SHALL load sw byte ioctl_addr[2:0] in the next cycle; no stall.
REQ-020 Other indices SHALL be ignored.
REQ-021 Falling edge of ioctl_download while index was 0 SHALL enter HOLD once any WRITE completes; a write arriving in the same cycle as the fall SHALL still be performed.
REQ-022 HOLD SHALL count RESET_HOLD cycles, then enter READY; rom_ready SHALL be high only in READY.
REQ-023 A new index-0 download starting in HOLD or READY SHALL clear rom_ready and resume IDLE-driven loading; err flags SHALL clear at download start.
REQ-024 board_reset SHALL be high whenever reset is high, rom_ready is low, or an index-0 download is active.
REQ-025 Timeout and hold counters SHALL saturate, never wrap.

Reset
REQ-026 Reset SHALL force IDLE, rom_we=0, ioctl_wait=0, rom_ready=0, board_reset=1, err flags=0, mod=8'hFF, sw=0, rom_sel/addr/data=0, counters=0.
REQ-027 Reset mid-WRITE SHALL abort the write immediately (asynchronous); the byte is not retried.

Structure
REQ-028 Region indices (main, sound, gfx, ...), ioctl index constants (0, 1, 254), and the state enum SHALL live in a shared package, e.g. mylstar_pkg.
REQ-029 Single module; no sub-module required (the hold counter may be inline).

Verification
REQ-030 Write idx0 addr 0x01234 data 0xA5, rom_ack 3 cycles later -> rom_sel=0, rom_addr=0x1234, rom_data=0xA5, rom_we and ioctl_wait high for 4 cycles, then low.
REQ-031 Write idx0 addr 0x00010, rom_ack never -> err_timeout=1 after 255 cycles in WRITE, ioctl_wait released.
REQ-032 Write idx254 addr 3 data 0x5C, idx1 addr 0 data 0x04 -> sw[31:24]=0x5C, mod=0x04, ioctl_wait stays 0.
REQ-033 Download drops with RESET_HOLD=16 -> board_reset high 16 more cycles, then rom_ready=1, board_reset=0.
REQ-034 ioctl_wr during WRITE -> err_overrun=1, outstanding write unchanged; reset asserted mid-WRITE -> rom_we=0, ioctl_wait=0, mod=0xFF.

Source files
------------

// File: rtl/rom_load_ctrl_pkg.sv
// Shared constants and types for the ROM download controller: hps_io indices,
// ROM region numbering and the controller state encoding.
package rom_load_ctrl_pkg;

  localparam logic [7:0]  IDX_ROM = 8'd0;
  localparam logic [7:0]  IDX_MOD = 8'd1;
  localparam logic [7:0]  IDX_DIP = 8'd254;

  // Only the first 512 KiB of the index-0 stream maps onto ROM regions.
  localparam logic [24:0] ROM_ADDR_LIMIT = 25'h0080000;

  typedef enum logic [2:0] {
    REGION_MAIN  = 3'd0,
    REGION_SOUND = 3'd1,
    REGION_GFX   = 3'd2,
    REGION_PROM  = 3'd3
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_HOLD,
    ST_READY
  } state_t;

endpackage

// File: rtl/rom_load_ctrl.sv
// ROM download controller: forwards index-0 bytes to the ROM regions with an
// ack handshake, captures mod/DIP bytes and sequences board reset around loading.
module rom_load_ctrl
  import rom_load_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int RESET_HOLD  = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [2:0]  rom_sel,
  output logic [15:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_we,
  input  logic        rom_ack,
  output logic [7:0]  mod,
  output logic [63:0] sw,
  output logic        board_reset,
  output logic        rom_ready,
  output logic        err_timeout,
  output logic        err_overrun
);

  localparam int ACK_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int HOLD_W = $clog2(RESET_HOLD + 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [ACK_W-1:0]  r_ackCnt;
  logic [HOLD_W-1:0] r_holdCnt;
  logic              r_dlPrev;
  logic              r_holdPending;
  logic [2:0]        r_romSel;
  logic [15:0]       r_romAddr;
  logic [7:0]        r_romData;
  logic [7:0]        r_mod;
  logic [63:0]       r_sw;
  logic              r_errTimeout;
  logic              r_errOverrun;

  logic w_dlActive;
  logic w_start;
  logic w_fall;
  logic w_romWr;
  logic w_modWr;
  logic w_dipWr;
  logic w_overrun;
  logic w_ackExpired;
  logic w_timeout;
  logic w_holdDone;
  logic w_accept;
  logic w_enterHold;

  // Download edges are judged on the index-0 stream only; the fall ignores the
  // current index because hps_io may already have moved on.
  assign w_dlActive   = ioctl_download && (ioctl_index == IDX_ROM);
  assign w_start      = w_dlActive && !r_dlPrev;
  assign w_fall       = r_dlPrev && !ioctl_download;
  assign w_romWr      = ioctl_wr && (ioctl_index == IDX_ROM) && (ioctl_addr < ROM_ADDR_LIMIT);
  assign w_modWr      = ioctl_wr && (ioctl_index == IDX_MOD) && (ioctl_addr == '0);
  assign w_dipWr      = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0);
  assign w_overrun    = (r_state == ST_WRITE) && ioctl_wr && (ioctl_index == IDX_ROM);
  assign w_ackExpired = (r_ackCnt == ACK_W'(ACK_TIMEOUT - 1));
  assign w_timeout    = (r_state == ST_WRITE) && !rom_ack && w_ackExpired;
  assign w_holdDone   = (r_holdCnt == HOLD_W'(RESET_HOLD - 1));
  assign w_accept     = (r_state != ST_WRITE) && (w_nextState == ST_WRITE);
  assign w_enterHold  = (r_state != ST_HOLD) && (w_nextState == ST_HOLD);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // A pending download end waits behind any byte still in flight.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_romWr)                                    w_nextState = ST_WRITE;
        else if ((w_fall || r_holdPending) && !w_start) w_nextState = ST_HOLD;
      end
      ST_WRITE: begin
        if (rom_ack || w_ackExpired) w_nextState = ST_IDLE;
      end
      ST_HOLD, ST_READY: begin
        if (w_start)                                    w_nextState = w_romWr ? ST_WRITE : ST_IDLE;
        else if (r_state == ST_HOLD && w_holdDone)      w_nextState = ST_READY;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    rom_we      = (r_state == ST_WRITE);
    ioctl_wait  = (r_state == ST_WRITE);
    rom_ready   = (r_state == ST_READY);
    board_reset = reset || (r_state != ST_READY) || w_dlActive;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_ackCnt      <= '0;
      r_holdCnt     <= '0;
      r_dlPrev      <= 1'b0;
      r_holdPending <= 1'b0;
      r_romSel      <= '0;
      r_romAddr     <= '0;
      r_romData     <= '0;
      r_mod         <= 8'hFF;
      r_sw          <= '0;
      r_errTimeout  <= 1'b0;
      r_errOverrun  <= 1'b0;
    end else begin
      r_dlPrev <= w_dlActive;

      if (w_accept) begin
        r_romSel  <= ioctl_addr[18:16];
        r_romAddr <= ioctl_addr[15:0];
        r_romData <= ioctl_dout;
      end

      if (r_state != ST_WRITE)                r_ackCnt <= '0;
      else if (r_ackCnt != ACK_W'(ACK_TIMEOUT)) r_ackCnt <= r_ackCnt + ACK_W'(1);

      if (r_state != ST_HOLD)                   r_holdCnt <= '0;
      else if (r_holdCnt != HOLD_W'(RESET_HOLD)) r_holdCnt <= r_holdCnt + HOLD_W'(1);

      if (w_enterHold)  r_holdPending <= 1'b0;
      else if (w_fall)  r_holdPending <= 1'b1;
      else if (w_start) r_holdPending <= 1'b0;

      // Errors raised in the same cycle as a new download start survive it.
      if (w_timeout)    r_errTimeout <= 1'b1;
      else if (w_start) r_errTimeout <= 1'b0;

      if (w_overrun)    r_errOverrun <= 1'b1;
      else if (w_start) r_errOverrun <= 1'b0;

      if (w_modWr) r_mod <= ioctl_dout;
      if (w_dipWr) r_sw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  assign rom_sel     = r_romSel;
  assign rom_addr    = r_romAddr;
  assign rom_data    = r_romData;
  assign mod         = r_mod;
  assign sw          = r_sw;
  assign err_timeout = r_errTimeout;
  assign err_overrun = r_errOverrun;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Bench for rom_load_ctrl: directed scenarios with literal expectations, then a
// randomized run compared every cycle against a cycle-level behavioural model.
module tb_rom_load_ctrl;

  localparam int ACK_TIMEOUT = 255;
  localparam int RESET_HOLD  = 16;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        rom_ack = 1'b0;
  logic        ioctl_wait;
  logic [2:0]  rom_sel;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_we;
  logic [7:0]  mod;
  logic [63:0] sw;
  logic        board_reset;
  logic        rom_ready;
  logic        err_timeout;
  logic        err_overrun;

  int checkCount = 0;
  int errorCount = 0;

  rom_load_ctrl #(
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .RESET_HOLD (RESET_HOLD)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_index   (ioctl_index),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .rom_sel       (rom_sel),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .rom_we        (rom_we),
    .rom_ack       (rom_ack),
    .mod           (mod),
    .sw            (sw),
    .board_reset   (board_reset),
    .rom_ready     (rom_ready),
    .err_timeout   (err_timeout),
    .err_overrun   (err_overrun)
  );

  always #5 clk_sys = ~clk_sys;

  // The model tracks the loader as "a byte in flight", "hold cycles left" and
  // "game ready", advanced once per clock from the same inputs the DUT sees.
  typedef struct {
    logic        busy;
    int          waited;
    int          holdLeft;
    logic        ready;
    logic        pending;
    logic        dlPrev;
    logic        errT;
    logic        errO;
    logic [2:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  modv;
    logic [63:0] swv;
  } model_t;

  model_t m;

  function automatic model_t modelReset();
    model_t s;
    s.busy = 1'b0; s.waited = 0; s.holdLeft = 0; s.ready = 1'b0;
    s.pending = 1'b0; s.dlPrev = 1'b0; s.errT = 1'b0; s.errO = 1'b0;
    s.sel = 3'd0; s.addr = 16'd0; s.data = 8'd0; s.modv = 8'hFF; s.swv = 64'd0;
    return s;
  endfunction

  function automatic model_t modelStep(input model_t cur);
    model_t s;
    logic start, fall, romWr, idle, enteredHold;
    s = cur;
    start = ioctl_download && ioctl_index == 8'd0 && !cur.dlPrev;
    fall = cur.dlPrev && !ioctl_download;
    romWr = ioctl_wr && ioctl_index == 8'd0 && ioctl_addr < 25'h80000;
    idle = !cur.busy && cur.holdLeft == 0 && !cur.ready;
    enteredHold = 1'b0;
    if (ioctl_wr && ioctl_index == 8'd1 && ioctl_addr == 25'd0) s.modv = ioctl_dout;
    if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'd8)
      s.swv[8 * int'(ioctl_addr[2:0]) +: 8] = ioctl_dout;
    if (start) begin
      s.errT = 1'b0;
      s.errO = 1'b0;
    end
    if (cur.busy) begin
      if (ioctl_wr && ioctl_index == 8'd0) s.errO = 1'b1;
      s.waited = cur.waited + 1;
      if (rom_ack) s.busy = 1'b0;
      else if (s.waited >= ACK_TIMEOUT) begin
        s.busy = 1'b0;
        s.errT = 1'b1;
      end
    end else if (idle || start) begin
      if (start) begin
        s.holdLeft = 0;
        s.ready = 1'b0;
      end
      if (romWr && (idle || start)) begin
        s.busy = 1'b1; s.waited = 0;
        s.sel = ioctl_addr[18:16]; s.addr = ioctl_addr[15:0]; s.data = ioctl_dout;
      end else if (idle && (fall || cur.pending) && !start) begin
        s.holdLeft = RESET_HOLD;
        enteredHold = 1'b1;
      end
    end else if (cur.holdLeft > 0) begin
      s.holdLeft = cur.holdLeft - 1;
      if (s.holdLeft == 0) s.ready = 1'b1;
    end
    if (enteredHold) s.pending = 1'b0;
    else if (fall)   s.pending = 1'b1;
    else if (start)  s.pending = 1'b0;
    s.dlPrev = ioctl_download && ioctl_index == 8'd0;
    return s;
  endfunction

  always @(posedge clk_sys or posedge reset) begin
    if (reset) m <= modelReset();
    else       m <= modelStep(m);
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic dl, input logic wr, input logic [7:0] idx,
                               input logic [24:0] addr, input logic [7:0] dout, input logic ack);
    ioctl_download = dl;
    ioctl_wr = wr;
    ioctl_index = idx;
    ioctl_addr = addr;
    ioctl_dout = dout;
    rom_ack = ack;
    @(posedge clk_sys);
    #1;
  endtask

  always @(negedge clk_sys) begin
    checkOutput("rom_we", 64'(rom_we), 64'(m.busy));
    checkOutput("ioctl_wait", 64'(ioctl_wait), 64'(m.busy));
    checkOutput("rom_ready", 64'(rom_ready), 64'(m.ready));
    checkOutput("board_reset", 64'(board_reset),
                64'(reset || !m.ready || (ioctl_download && ioctl_index == 8'd0)));
    checkOutput("err_timeout", 64'(err_timeout), 64'(m.errT));
    checkOutput("err_overrun", 64'(err_overrun), 64'(m.errO));
    checkOutput("rom_sel", 64'(rom_sel), 64'(m.sel));
    checkOutput("rom_addr", 64'(rom_addr), 64'(m.addr));
    checkOutput("rom_data", 64'(rom_data), 64'(m.data));
    checkOutput("mod", 64'(mod), 64'(m.modv));
    checkOutput("sw", sw, m.swv);
  end

  initial begin
    #1000000;
    errorCount++;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int weCount;
    int holdCount;
    logic dlState;
    logic [7:0] idx;
    logic [24:0] addr;
    int r;

    repeat (3) @(posedge clk_sys);
    #1;
    checkOutput("reset board_reset", 64'(board_reset), 64'd1);
    checkOutput("reset rom_we", 64'(rom_we), 64'd0);
    checkOutput("reset ioctl_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("reset rom_ready", 64'(rom_ready), 64'd0);
    checkOutput("reset mod", 64'(mod), 64'hFF);
    checkOutput("reset sw", sw, 64'd0);
    checkOutput("reset err_timeout", 64'(err_timeout), 64'd0);
    reset = 1'b0;

    // One byte acknowledged in its fourth WRITE cycle.
    applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd0, 25'h01234, 8'hA5, 1'b0);
    checkOutput("wr1 rom_sel", 64'(rom_sel), 64'd0);
    checkOutput("wr1 rom_addr", 64'(rom_addr), 64'h1234);
    checkOutput("wr1 rom_data", 64'(rom_data), 64'hA5);
    checkOutput("wr1 ioctl_wait", 64'(ioctl_wait), 64'd1);
    weCount = 0;
    for (int k = 0; k < 6; k++) begin
      if (rom_we) weCount++;
      applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, k == 3);
    end
    checkOutput("wr1 we cycles", 64'(weCount), 64'd4);
    checkOutput("wr1 rom_we released", 64'(rom_we), 64'd0);
    checkOutput("wr1 ioctl_wait released", 64'(ioctl_wait), 64'd0);

    // Second write arrives while the first is outstanding.
    applyStimulus(1'b1, 1'b1, 8'd0, 25'h20010, 8'h3C, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'd0, 25'h00055, 8'h99, 1'b0);
    checkOutput("ovr err_overrun", 64'(err_overrun), 64'd1);
    checkOutput("ovr rom_sel", 64'(rom_sel), 64'd2);
    checkOutput("ovr rom_addr", 64'(rom_addr), 64'h0010);
    checkOutput("ovr rom_data", 64'(rom_data), 64'h3C);
    checkOutput("ovr rom_we", 64'(rom_we), 64'd1);
    applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b1);
    checkOutput("ovr rom_we after ack", 64'(rom_we), 64'd0);

    // Write that is never acknowledged.
    applyStimulus(1'b1, 1'b1, 8'd0, 25'h00010, 8'h11, 1'b0);
    weCount = 0;
    for (int k = 0; k < 400; k++) begin
      if (!rom_we) break;
      weCount++;
      applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
    end
    checkOutput("tmo write cycles", 64'(weCount), 64'd255);
    checkOutput("tmo err_timeout", 64'(err_timeout), 64'd1);
    checkOutput("tmo ioctl_wait", 64'(ioctl_wait), 64'd0);

    // Download ends: the cycle the drop is seen, then the hold period.
    applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
    holdCount = 0;
    for (int k = 0; k < 100; k++) begin
      if (rom_ready) break;
      if (board_reset) holdCount++;
      applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
    end
    checkOutput("hold cycles", 64'(holdCount), 64'd16);
    checkOutput("hold rom_ready", 64'(rom_ready), 64'd1);
    checkOutput("hold board_reset", 64'(board_reset), 64'd0);

    applyStimulus(1'b1, 1'b1, 8'd254, 25'd3, 8'h5C, 1'b0);
    checkOutput("dip ioctl_wait", 64'(ioctl_wait), 64'd0);
    applyStimulus(1'b1, 1'b1, 8'd1, 25'd0, 8'h04, 1'b0);
    checkOutput("mod ioctl_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("dip sw[31:24]", 64'(sw[31:24]), 64'h5C);
    checkOutput("mod value", 64'(mod), 64'h04);
    checkOutput("mod keeps rom_ready", 64'(rom_ready), 64'd1);

    // A fresh ROM download from READY.
    applyStimulus(1'b1, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
    checkOutput("restart rom_ready", 64'(rom_ready), 64'd0);
    checkOutput("restart err_timeout", 64'(err_timeout), 64'd0);
    checkOutput("restart err_overrun", 64'(err_overrun), 64'd0);

    applyStimulus(1'b1, 1'b1, 8'd0, 25'h10077, 8'h42, 1'b0);
    checkOutput("abort rom_we before", 64'(rom_we), 64'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abort rom_we", 64'(rom_we), 64'd0);
    checkOutput("abort ioctl_wait", 64'(ioctl_wait), 64'd0);
    checkOutput("abort mod", 64'(mod), 64'hFF);
    checkOutput("abort board_reset", 64'(board_reset), 64'd1);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
    checkOutput("abort not retried", 64'(rom_we), 64'd0);

    dlState = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'd0, 25'd0, 8'd0, 1'b0);
        reset = 1'b0;
        continue;
      end
      if ($urandom_range(0, 149) == 0) dlState = !dlState;
      r = int'($urandom_range(0, 9));
      if (dlState) idx = (r < 8) ? 8'd0 : ((r == 8) ? 8'd1 : 8'd254);
      else         idx = (r < 4) ? 8'd0 : (r < 6) ? 8'd1 : (r < 8) ? 8'd254 : 8'd37;
      case (idx)
        8'd0:    addr = 25'($urandom_range(0, 32'h9FFFF));
        8'd1:    addr = ($urandom_range(0, 1) == 0) ? 25'd0 : 25'($urandom_range(1, 3));
        8'd254:  addr = 25'($urandom_range(0, 11));
        default: addr = 25'($urandom_range(0, 32'h1FFFFFF));
      endcase
      applyStimulus(dlState, $urandom_range(0, 2) == 0, idx, addr,
                    8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
